// File: rtl/regfile_write_arbiter_if.sv
// Register-file write-port bundle: two valid/ready write requesters, clear
// request/status, and the registered we/waddr/wdata/wsrc outputs.
`default_nettype none

interface regfile_write_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;

  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;

  logic              clear_req;
  logic              busy;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_wsrc;

  // Requesters and the register file, seen from outside the arbiter.
  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output clear_req,
    input  req0_ready, req1_ready, busy,
    input  rf_we, rf_waddr, rf_wdata, rf_wsrc
  );

  // The arbiter itself.
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  clear_req,
    output req0_ready, req1_ready, busy,
    output rf_we, rf_waddr, rf_wdata, rf_wsrc
  );
endinterface

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module : regfile_write_arbiter                                           |
// | Round-robin owner of the register-file write port with a zeroing sweep   |
// | after reset and on clear_req.                                            |
// | Rev    : 1.1                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module regfile_write_arbiter #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 16
) (
    input  wire                     clk,
    input  wire                     rst,
    regfile_write_arbiter_if.slave  bus
);

    localparam logic [0:0] c_ST_CLEAR = 1'b0;
    localparam logic [0:0] c_ST_RUN   = 1'b1;

    localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(NUM_REGS - 1);

    logic [0:0]        r_state, w_state_next;
    logic [ADDR_W-1:0] r_cnt, w_cnt_next;
    logic              r_last_grant, w_last_grant_next;

    logic              r_rf_we, w_rf_we_next;
    logic [ADDR_W-1:0] r_rf_waddr, w_rf_waddr_next;
    logic [DATA_W-1:0] r_rf_wdata, w_rf_wdata_next;
    logic              r_rf_wsrc, w_rf_wsrc_next;

    logic              w_grant0, w_grant1;

    // A requester wins when alone, or on a tie when it was not granted last.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (r_state == c_ST_RUN && !bus.clear_req) begin
            w_grant0 = bus.req0_valid && (!bus.req1_valid || r_last_grant);
            w_grant1 = bus.req1_valid && (!bus.req0_valid || !r_last_grant);
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_last_grant_next = r_last_grant;
        w_rf_we_next      = 1'b0;
        w_rf_waddr_next   = r_rf_waddr;
        w_rf_wdata_next   = r_rf_wdata;
        w_rf_wsrc_next    = r_rf_wsrc;

        case (r_state)
            c_ST_CLEAR: begin
                w_rf_we_next    = 1'b1;
                w_rf_waddr_next = r_cnt;
                w_rf_wdata_next = '0;
                w_rf_wsrc_next  = 1'b0;
                if (r_cnt == c_LAST_IDX) begin
                    w_state_next = c_ST_RUN;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            c_ST_RUN: begin
                if (bus.clear_req) begin
                    w_state_next = c_ST_CLEAR;
                    w_cnt_next   = '0;
                end else if (w_grant0) begin
                    w_rf_we_next      = 1'b1;
                    w_rf_waddr_next   = bus.req0_addr;
                    w_rf_wdata_next   = bus.req0_data;
                    w_rf_wsrc_next    = 1'b0;
                    w_last_grant_next = 1'b0;
                end else if (w_grant1) begin
                    w_rf_we_next      = 1'b1;
                    w_rf_waddr_next   = bus.req1_addr;
                    w_rf_wdata_next   = bus.req1_data;
                    w_rf_wsrc_next    = 1'b1;
                    w_last_grant_next = 1'b1;
                end
            end
            default: begin
                w_state_next = c_ST_CLEAR;
                w_cnt_next   = '0;
            end
        endcase
    end

    // last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_CLEAR;
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
            r_rf_we      <= 1'b0;
            r_rf_waddr   <= '0;
            r_rf_wdata   <= '0;
            r_rf_wsrc    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_last_grant <= w_last_grant_next;
            r_rf_we      <= w_rf_we_next;
            r_rf_waddr   <= w_rf_waddr_next;
            r_rf_wdata   <= w_rf_wdata_next;
            r_rf_wsrc    <= w_rf_wsrc_next;
        end
    end

    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;
    assign bus.busy       = (r_state == c_ST_CLEAR);
    assign bus.rf_we      = r_rf_we;
    assign bus.rf_waddr   = r_rf_waddr;
    assign bus.rf_wdata   = r_rf_wdata;
    assign bus.rf_wsrc    = r_rf_wsrc;

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter with a behavioural
// 16x16 register file fed from the rf_* outputs for readback checks.
`default_nettype none

module tb_regfile_write_arbiter;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;

  logic clk;
  logic rst;
  int   tests;
  int   errors;

  logic [DATA_W-1:0] mem [NUM_REGS];

  regfile_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_write_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.rf_we) mem[bus.rf_waddr] <= bus.rf_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    bus.clear_req  = 1'b0;
  endtask

  // Expects the FSM to be at clear cycle 0; walks the full sweep.
  task automatic check_sweep(input string tag);
    for (int i = 0; i < NUM_REGS; i++) begin
      chk({tag, " busy"}, 32'(bus.busy), 32'd1);
      chk({tag, " rdy0"}, 32'(bus.req0_ready), 32'd0);
      chk({tag, " rdy1"}, 32'(bus.req1_ready), 32'd0);
      tick();
      chk({tag, " we"}, 32'(bus.rf_we), 32'd1);
      chk({tag, " waddr"}, 32'(bus.rf_waddr), 32'(i));
      chk({tag, " wdata"}, 32'(bus.rf_wdata), 32'd0);
      chk({tag, " wsrc"}, 32'(bus.rf_wsrc), 32'd0);
    end
    chk({tag, " busy end"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    chk("rst busy", 32'(bus.busy), 32'd1);
    chk("rst we", 32'(bus.rf_we), 32'd0);
    chk("rst waddr", 32'(bus.rf_waddr), 32'd0);
    chk("rst wdata", 32'(bus.rf_wdata), 32'd0);
    chk("rst wsrc", 32'(bus.rf_wsrc), 32'd0);
    chk("rst rdy0", 32'(bus.req0_ready), 32'd0);
    chk("rst rdy1", 32'(bus.req1_ready), 32'd0);
    rst = 1'b0;
    check_sweep("init clr");
    tick();
    chk("post clr we", 32'(bus.rf_we), 32'd0);
    chk("post clr busy", 32'(bus.busy), 32'd0);
  endtask

  task automatic test_single();
    bus.req0_valid = 1'b1; bus.req0_addr = 4'd3; bus.req0_data = 16'hBEEF;
    #1;
    chk("single rdy0", 32'(bus.req0_ready), 32'd1);
    chk("single rdy1", 32'(bus.req1_ready), 32'd0);
    tick();
    bus.req0_valid = 1'b0;
    chk("single we", 32'(bus.rf_we), 32'd1);
    chk("single waddr", 32'(bus.rf_waddr), 32'd3);
    chk("single wdata", 32'(bus.rf_wdata), 32'hBEEF);
    chk("single wsrc", 32'(bus.rf_wsrc), 32'd0);
    tick();
    chk("idle we", 32'(bus.rf_we), 32'd0);
    chk("idle waddr hold", 32'(bus.rf_waddr), 32'd3);
    chk("idle wdata hold", 32'(bus.rf_wdata), 32'hBEEF);
    chk("readback r3", 32'(mem[3]), 32'hBEEF);
    // Lone req1 write leaves last_grant=1 so the next tie goes to req0.
    bus.req1_valid = 1'b1; bus.req1_addr = 4'd7; bus.req1_data = 16'h7777;
    #1;
    chk("lone1 rdy1", 32'(bus.req1_ready), 32'd1);
    tick();
    bus.req1_valid = 1'b0;
    chk("lone1 wsrc", 32'(bus.rf_wsrc), 32'd1);
    chk("lone1 wdata", 32'(bus.rf_wdata), 32'h7777);
    tick();
    chk("readback r7", 32'(mem[7]), 32'h7777);
  endtask

  task automatic test_round_robin();
    logic w;
    bus.req0_valid = 1'b1; bus.req0_addr = 4'd1; bus.req0_data = 16'h1111;
    bus.req1_valid = 1'b1; bus.req1_addr = 4'd2; bus.req1_data = 16'h2222;
    for (int i = 0; i < 5; i++) begin
      w = i[0];
      #1;
      chk("rr rdy0", 32'(bus.req0_ready), 32'(!w));
      chk("rr rdy1", 32'(bus.req1_ready), 32'(w));
      tick();
      chk("rr we", 32'(bus.rf_we), 32'd1);
      chk("rr wsrc", 32'(bus.rf_wsrc), 32'(w));
      chk("rr waddr", 32'(bus.rf_waddr), w ? 32'd2 : 32'd1);
      chk("rr wdata", 32'(bus.rf_wdata), w ? 32'h2222 : 32'h1111);
    end
    idle_inputs();
    tick();
    chk("rr r1", 32'(mem[1]), 32'h1111);
    chk("rr r2", 32'(mem[2]), 32'h2222);
  endtask

  // Entered with last_grant=0: req1 goes first, req0 second and wins.
  task automatic test_same_addr();
    bus.req0_valid = 1'b1; bus.req0_addr = 4'd5; bus.req0_data = 16'hAAAA;
    bus.req1_valid = 1'b1; bus.req1_addr = 4'd5; bus.req1_data = 16'h5555;
    #1;
    chk("same rdy0 a", 32'(bus.req0_ready), 32'd0);
    chk("same rdy1 a", 32'(bus.req1_ready), 32'd1);
    tick();
    bus.req1_valid = 1'b0;
    chk("same wdata a", 32'(bus.rf_wdata), 32'h5555);
    chk("same wsrc a", 32'(bus.rf_wsrc), 32'd1);
    #1;
    chk("same rdy0 b", 32'(bus.req0_ready), 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    chk("same wdata b", 32'(bus.rf_wdata), 32'hAAAA);
    chk("same wsrc b", 32'(bus.rf_wsrc), 32'd0);
    tick();
    chk("same r5", 32'(mem[5]), 32'hAAAA);
  endtask

  task automatic test_clear_req();
    bus.req1_valid = 1'b1; bus.req1_addr = 4'd9; bus.req1_data = 16'h9999;
    bus.clear_req  = 1'b1;
    #1;
    chk("clr rdy1", 32'(bus.req1_ready), 32'd0);
    chk("clr rdy0", 32'(bus.req0_ready), 32'd0);
    tick();
    bus.clear_req = 1'b0;
    chk("clr cyc we", 32'(bus.rf_we), 32'd0);
    check_sweep("reclr");
    #1;
    chk("clr first run rdy1", 32'(bus.req1_ready), 32'd1);
    tick();
    bus.req1_valid = 1'b0;
    chk("clr post waddr", 32'(bus.rf_waddr), 32'd9);
    chk("clr post wsrc", 32'(bus.rf_wsrc), 32'd1);
    tick();
    for (int i = 0; i < NUM_REGS; i++) begin
      chk("clr readback", 32'(mem[i]), (i == 9) ? 32'h9999 : 32'd0);
    end
  endtask

  task automatic test_reset_mid_clear();
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("mid waddr pre", 32'(bus.rf_waddr), 32'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid rst we", 32'(bus.rf_we), 32'd0);
    chk("mid rst waddr", 32'(bus.rf_waddr), 32'd0);
    check_sweep("restart");
    tick();
    chk("restart end we", 32'(bus.rf_we), 32'd0);
  endtask

  initial begin
    tests  = 0;
    errors = 0;
    rst    = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_same_addr();
    test_clear_req();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

`default_nettype wire
